// File: rtl/ps2_key_scheduler.sv
// PS/2 game-key scheduler: tracks held action keys, raises one-shot and
// auto-repeat requests, and issues them round-robin on a valid/ready stream.
module ps2_key_scheduler #(
    parameter int unsigned REPEAT_DELAY  = 25_000_000,
    parameter int unsigned REPEAT_PERIOD = 10_000_000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key_code,
    input  logic       key_valid,
    input  logic       op_ready,
    output logic       op_valid,
    output logic [2:0] op_code,
    output logic [5:0] held,
    output logic [7:0] drop_cnt
);

    localparam logic [2:0] OP_SELECT = 3'd0;
    localparam logic [2:0] OP_LEFT   = 3'd1;
    localparam logic [2:0] OP_RIGHT  = 3'd2;
    localparam logic [2:0] OP_UP     = 3'd3;
    localparam logic [2:0] OP_DOWN   = 3'd4;
    localparam logic [2:0] OP_CANCEL = 3'd5;

    logic [5:0]       pending;
    logic [2:0]       rr_ptr;
    logic             rep_active;
    logic [2:0]       rep_key;
    logic [CNT_W-1:0] rep_timer;

    logic       map_hit;
    logic [2:0] act;
    logic       ev_make, ev_break, dir_make, cancel_make;
    logic       rep_stop, rep_expire, rep_fire;
    logic       load, grant_hit, grant_take;
    logic [2:0] grant_idx;
    logic [3:0] cand;
    logic [5:0] grant_mask, make_mask, rep_mask, pending_next;
    logic       drop_make, drop_rep;
    logic [8:0] drop_sum;
    logic [7:0] drop_next;

    // Key map is matched on {expand, scancode}; the break bit is handled separately.
    always_comb begin
        map_hit = 1'b0;
        act     = OP_SELECT;
        case ({key_code[9], key_code[7:0]})
            9'h05A, 9'h029: begin map_hit = 1'b1; act = OP_SELECT; end
            9'h16B, 9'h01C: begin map_hit = 1'b1; act = OP_LEFT;   end
            9'h174, 9'h023: begin map_hit = 1'b1; act = OP_RIGHT;  end
            9'h175, 9'h01D: begin map_hit = 1'b1; act = OP_UP;     end
            9'h172, 9'h01B: begin map_hit = 1'b1; act = OP_DOWN;   end
            9'h076:         begin map_hit = 1'b1; act = OP_CANCEL; end
            default: ;
        endcase
    end

    assign ev_make     = key_valid && map_hit && !key_code[8] && !held[act];
    assign ev_break    = key_valid && map_hit && key_code[8];
    assign dir_make    = ev_make && (act != OP_SELECT) && (act != OP_CANCEL);
    assign cancel_make = ev_make && (act == OP_CANCEL);

    // Any event that ends the current repeat also suppresses an expiry in the same cycle.
    assign rep_stop   = dir_make || cancel_make || (ev_break && rep_active && (act == rep_key));
    assign rep_expire = rep_active && !rep_stop && (rep_timer == CNT_W'(1));
    assign rep_fire   = rep_expire && held[rep_key];

    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= 6; i++) begin
            cand = {1'b0, rr_ptr} + 4'(i);
            if (cand >= 4'd6)
                cand = cand - 4'd6;
            if (!grant_hit && pending[cand[2:0]]) begin
                grant_hit = 1'b1;
                grant_idx = cand[2:0];
            end
        end
    end

    assign load       = !op_valid || op_ready;
    assign grant_take = load && grant_hit;
    assign grant_mask = grant_take ? (6'b000001 << grant_idx) : '0;
    assign make_mask  = ev_make    ? (6'b000001 << act)       : '0;
    assign rep_mask   = rep_fire   ? (6'b000001 << rep_key)   : '0;

    // A set landing on a bit being granted this cycle re-arms it without counting as a drop.
    assign drop_make = ev_make  && pending[act]     && !grant_mask[act];
    assign drop_rep  = rep_fire && pending[rep_key] && !grant_mask[rep_key];

    always_comb begin
        pending_next = pending & ~grant_mask;
        if (cancel_make)
            pending_next[4:0] = '0;
        pending_next = pending_next | make_mask | rep_mask;
    end

    assign drop_sum  = {1'b0, drop_cnt} + 9'(drop_make) + 9'(drop_rep);
    assign drop_next = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid   <= 1'b0;
            op_code    <= '0;
            held       <= '0;
            drop_cnt   <= '0;
            pending    <= '0;
            rr_ptr     <= OP_CANCEL;
            rep_active <= 1'b0;
            rep_key    <= '0;
            rep_timer  <= '0;
        end else begin
            pending  <= pending_next;
            drop_cnt <= drop_next;

            if (ev_make)
                held[act] <= 1'b1;
            else if (ev_break)
                held[act] <= 1'b0;

            if (dir_make) begin
                rep_active <= 1'b1;
                rep_key    <= act;
                rep_timer  <= CNT_W'(REPEAT_DELAY);
            end else if (rep_stop) begin
                rep_active <= 1'b0;
            end else if (rep_expire) begin
                if (held[rep_key])
                    rep_timer <= CNT_W'(REPEAT_PERIOD);
                else
                    rep_active <= 1'b0;
            end else if (rep_active) begin
                rep_timer <= rep_timer - CNT_W'(1);
            end

            if (load) begin
                if (grant_hit) begin
                    op_valid <= 1'b1;
                    op_code  <= grant_idx;
                    rr_ptr   <= grant_idx;
                end else begin
                    op_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_scheduler.sv
// Directed bench for ps2_key_scheduler: vector table for single-cycle behaviour,
// hand-written sequences for repeat timing, cancel, async reset and saturation.
module tb_ps2_key_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] key_code;
    logic       key_valid;
    logic       op_ready;
    logic       op_valid;
    logic [2:0] op_code;
    logic [5:0] held;
    logic [7:0] drop_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    ps2_key_scheduler #(
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(5),
        .CNT_W        (26)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .op_ready (op_ready),
        .op_valid (op_valid),
        .op_code  (op_code),
        .held     (held),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       kv;
        logic [9:0] code;
        logic       rdy;
        logic       ev;
        logic [2:0] ec;
        logic [5:0] eh;
        logic [7:0] ed;
    } vec_t;

    vec_t vecs[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [9:0] code);
        key_code  = code;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // kv, code, rdy, exp valid, exp code, exp held, exp drop
        vecs[0]  = '{1'b1, 10'h272, 1'b1, 1'b0, 3'd0, 6'h10, 8'd0};
        vecs[1]  = '{1'b0, 10'h000, 1'b1, 1'b1, 3'd4, 6'h10, 8'd0};
        vecs[2]  = '{1'b0, 10'h000, 1'b1, 1'b0, 3'd4, 6'h10, 8'd0};
        vecs[3]  = '{1'b1, 10'h372, 1'b1, 1'b0, 3'd4, 6'h00, 8'd0};
        vecs[4]  = '{1'b1, 10'h01C, 1'b1, 1'b0, 3'd4, 6'h02, 8'd0};
        vecs[5]  = '{1'b1, 10'h01C, 1'b1, 1'b1, 3'd1, 6'h02, 8'd0};
        vecs[6]  = '{1'b1, 10'h01C, 1'b1, 1'b0, 3'd1, 6'h02, 8'd0};
        vecs[7]  = '{1'b0, 10'h000, 1'b1, 1'b0, 3'd1, 6'h02, 8'd0};
        vecs[8]  = '{1'b1, 10'h11C, 1'b1, 1'b0, 3'd1, 6'h00, 8'd0};
        vecs[9]  = '{1'b1, 10'h05A, 1'b0, 1'b0, 3'd1, 6'h01, 8'd0};
        vecs[10] = '{1'b1, 10'h275, 1'b0, 1'b1, 3'd0, 6'h09, 8'd0};
        vecs[11] = '{1'b1, 10'h272, 1'b0, 1'b1, 3'd0, 6'h19, 8'd0};
        vecs[12] = '{1'b1, 10'h375, 1'b0, 1'b1, 3'd0, 6'h11, 8'd0};
        vecs[13] = '{1'b1, 10'h275, 1'b0, 1'b1, 3'd0, 6'h19, 8'd1};
        vecs[14] = '{1'b0, 10'h000, 1'b1, 1'b1, 3'd3, 6'h19, 8'd1};
        vecs[15] = '{1'b0, 10'h000, 1'b1, 1'b1, 3'd4, 6'h19, 8'd1};
        vecs[16] = '{1'b0, 10'h000, 1'b1, 1'b0, 3'd4, 6'h19, 8'd1};
        vecs[17] = '{1'b1, 10'h375, 1'b1, 1'b0, 3'd4, 6'h11, 8'd1};
        vecs[18] = '{1'b1, 10'h372, 1'b1, 1'b0, 3'd4, 6'h01, 8'd1};
        vecs[19] = '{1'b1, 10'h15A, 1'b1, 1'b0, 3'd4, 6'h00, 8'd1};

        rst_n     = 1'b0;
        key_code  = '0;
        key_valid = 1'b0;
        op_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("reset_valid", op_valid, 0);
        check("reset_code",  op_code,  0);
        check("reset_held",  held,     0);
        check("reset_drop",  drop_cnt, 0);

        for (int i = 0; i < 20; i++) begin
            key_code  = vecs[i].code;
            key_valid = vecs[i].kv;
            op_ready  = vecs[i].rdy;
            tick();
            key_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), op_valid, vecs[i].ev);
            check($sformatf("vec%0d_code", i),  op_code,  vecs[i].ec);
            check($sformatf("vec%0d_held", i),  held,     vecs[i].eh);
            check($sformatf("vec%0d_drop", i),  drop_cnt, vecs[i].ed);
        end

        // Hold LEFT: ops at N+2, N+22, then every 5 cycles until the break.
        op_ready = 1'b1;
        send(10'h26B);
        check("rep_k1_valid", op_valid, 0);
        check("rep_k1_held",  held,     6'h02);
        for (int k = 2; k <= 60; k++) begin
            logic exp_v;
            if (k == 39) begin
                key_code  = 10'h36B;
                key_valid = 1'b1;
            end
            tick();
            key_valid = 1'b0;
            exp_v = (k == 2 || k == 22 || k == 27 || k == 32 || k == 37);
            check($sformatf("rep_k%0d_valid", k), op_valid, exp_v);
            if (exp_v)
                check($sformatf("rep_k%0d_code", k), op_code, 1);
        end
        check("rep_held_after_break", held, 0);

        // CANCEL flushes pending directions and stops their repeat.
        op_ready = 1'b0;
        send(10'h05A);
        check("cxl_c1_valid", op_valid, 0);
        send(10'h26B);
        check("cxl_c2_valid", op_valid, 1);
        check("cxl_c2_code",  op_code,  0);
        send(10'h274);
        send(10'h076);
        check("cxl_c4_valid", op_valid, 1);
        check("cxl_c4_code",  op_code,  0);
        check("cxl_c4_held",  held,     6'h27);
        check("cxl_c4_drop",  drop_cnt, 1);
        op_ready = 1'b1;
        tick();
        check("cxl_c5_valid", op_valid, 1);
        check("cxl_c5_code",  op_code,  5);
        for (int k = 0; k < 30; k++) begin
            tick();
            check($sformatf("cxl_idle%0d_valid", k), op_valid, 0);
        end
        send(10'h15A);
        send(10'h36B);
        send(10'h374);
        send(10'h176);
        check("cxl_held_released", held, 0);

        // Async reset while an op is in flight and another is pending.
        op_ready = 1'b0;
        send(10'h05A);
        send(10'h275);
        check("rst_pre_valid", op_valid, 1);
        check("rst_pre_held",  held,     6'h09);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", op_valid, 0);
        check("rst_async_code",  op_code,  0);
        check("rst_async_held",  held,     0);
        check("rst_async_drop",  drop_cnt, 0);
        tick();
        #2 rst_n = 1'b1;
        op_ready = 1'b1;
        repeat (3) tick();
        check("rst_post_valid", op_valid, 0);
        check("rst_post_held",  held,     0);

        // Coalesced SELECT makes while the output is stalled.
        op_ready = 1'b0;
        send(10'h05A);
        for (int i = 0; i < 302; i++) begin
            send(10'h15A);
            send(10'h05A);
            if (i == 99)
                check("sat_drop_99", drop_cnt, 99);
            if (i == 254)
                check("sat_drop_254", drop_cnt, 254);
        end
        check("sat_drop_final", drop_cnt, 255);
        check("sat_valid",      op_valid, 1);
        check("sat_code",       op_code,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
